// File: rtl/kernel_dispatcher.sv
// rtl/kernel_dispatcher.sv - splits a kernel launch into thread blocks, issues them to free cores, tracks halts
// Defining DISPATCH_PERF_EN enables the busy-cycle counter on perf_cycles.
module kernel_dispatcher #(
   parameter int NUM_CORES    = 2,
   parameter int NUM_THREADS  = 4,
   parameter int TCOUNT_WIDTH = 8,
   parameter int PC_WIDTH     = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [TCOUNT_WIDTH-1:0] thread_count,
   input  logic [PC_WIDTH-1:0]     base_pc,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_CORES-1:0]    core_launch,
   output logic [TCOUNT_WIDTH-1:0] core_block_id,
   output logic [NUM_THREADS-1:0]  core_thread_mask,
   output logic [PC_WIDTH-1:0]     core_pc,
   input  logic [NUM_CORES-1:0]    core_halt,
   output logic [31:0]             perf_cycles
);
   localparam int BW = TCOUNT_WIDTH + 1;
   localparam logic [NUM_THREADS-1:0] ALL_ONES = '1;

   typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_WAIT, S_FINISH} state_t;

   state_t                  state_q, state_d;
   logic [BW-1:0]           total_q, total_d, rem_q, rem_d, next_q, next_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d, core_pc_q, core_pc_d;
   logic [NUM_CORES-1:0]    cbusy_q, cbusy_d, launch_q, launch_d, launch_prev_q, launch_prev_d;
   logic [TCOUNT_WIDTH-1:0] block_id_q, block_id_d;
   logic [NUM_THREADS-1:0]  mask_q, mask_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [BW-1:0]           tc_ext, total_new, rem_new;
   logic [NUM_CORES-1:0]    sel_onehot;
   logic                    sel_valid, issue;

   assign tc_ext    = {1'b0, thread_count};
   assign total_new = (tc_ext + BW'(NUM_THREADS - 1)) / BW'(NUM_THREADS);
   assign rem_new   = tc_ext % BW'(NUM_THREADS);

   // Lowest-indexed free core wins; uses registered state so a core freed this edge waits a cycle.
   always_comb begin
      sel_onehot = '0;
      sel_valid  = 1'b0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!cbusy_q[i]) begin
            sel_onehot    = '0;
            sel_onehot[i] = 1'b1;
            sel_valid     = 1'b1;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      total_d       = total_q;
      rem_d         = rem_q;
      pc_d          = pc_q;
      next_d        = next_q;
      launch_d      = '0;
      block_id_d    = block_id_q;
      mask_d        = mask_q;
      core_pc_d     = core_pc_q;
      issue         = 1'b0;
      launch_prev_d = launch_q;
      // Halts during the launch cycle and the one after are the previous block's stale level.
      cbusy_d       = cbusy_q & ~(core_halt & ~launch_q & ~launch_prev_q);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               total_d = total_new;
               rem_d   = rem_new;
               pc_d    = base_pc;
               next_d  = '0;
               if (total_new == '0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_DISPATCH;
                  issue   = 1'b1;
               end
            end
         end
         S_DISPATCH: issue = (next_q < total_q) && sel_valid;
         S_WAIT:     if (cbusy_q == '0) state_d = S_FINISH;
         S_FINISH:   state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase

      if (issue) begin
         launch_d   = sel_onehot;
         block_id_d = next_d[TCOUNT_WIDTH-1:0];
         core_pc_d  = pc_d;
         mask_d     = ((next_d == total_d - BW'(1)) && (rem_d != '0)) ? ~(ALL_ONES << rem_d) : ALL_ONES;
         cbusy_d    = cbusy_d | sel_onehot;
         next_d     = next_d + BW'(1);
         if (next_d == total_d) state_d = S_WAIT;
      end

      done_d = (state_d == S_FINISH);
      busy_d = (state_d == S_DISPATCH) || (state_d == S_WAIT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         total_q       <= '0;
         rem_q         <= '0;
         next_q        <= '0;
         pc_q          <= '0;
         core_pc_q     <= '0;
         cbusy_q       <= '0;
         launch_q      <= '0;
         launch_prev_q <= '0;
         block_id_q    <= '0;
         mask_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         total_q       <= total_d;
         rem_q         <= rem_d;
         next_q        <= next_d;
         pc_q          <= pc_d;
         core_pc_q     <= core_pc_d;
         cbusy_q       <= cbusy_d;
         launch_q      <= launch_d;
         launch_prev_q <= launch_prev_d;
         block_id_q    <= block_id_d;
         mask_q        <= mask_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

`ifdef DISPATCH_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if ((state_q == S_IDLE) && start) begin
         perf_d = '0;
      end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) perf_q <= '0;
      else        perf_q <= perf_d;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

   assign busy             = busy_q;
   assign done             = done_q;
   assign core_launch      = launch_q;
   assign core_block_id    = block_id_q;
   assign core_thread_mask = mask_q;
   assign core_pc          = core_pc_q;

endmodule

// File: tb/tb_kernel_dispatcher.sv
// tb/tb_kernel_dispatcher.sv - directed scoreboard bench for kernel_dispatcher with modelled halting cores
module tb_kernel_dispatcher;
   localparam int HALT_DLY = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] thread_count = '0;
   logic [7:0] base_pc = '0;
   logic       busy, done;
   logic [1:0] core_launch;
   logic [7:0] core_block_id;
   logic [3:0] core_thread_mask;
   logic [7:0] core_pc;
   logic [1:0] core_halt = 2'b11;
   logic [31:0] perf_cycles;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         cyc;
      logic [1:0] launch;
      logic [7:0] blk;
      logic [3:0] mask;
      logic [7:0] pc;
   } exp_t;
   exp_t sb[$];

   kernel_dispatcher dut (
      .clk(clk), .reset(reset), .start(start), .thread_count(thread_count), .base_pc(base_pc),
      .busy(busy), .done(done), .core_launch(core_launch), .core_block_id(core_block_id),
      .core_thread_mask(core_thread_mask), .core_pc(core_pc), .core_halt(core_halt),
      .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   // Each core holds its stale halt for two cycles after launch, then halts HALT_DLY cycles after launch.
   int cnt[2] = '{0, 0};
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (core_launch[i]) cnt[i] = HALT_DLY;
         else if (cnt[i] > 0) cnt[i]--;
         core_halt[i] = (cnt[i] == 0) || (cnt[i] >= HALT_DLY - 1);
      end
   end

   function automatic int perf_exp(input int n);
`ifdef DISPATCH_PERF_EN
      return n;
`else
      return 0 * n;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [1:0] l, input logic [7:0] b, input logic [3:0] m, input logic [7:0] p);
      exp_t e;
      e.cyc = c; e.launch = l; e.blk = b; e.mask = m; e.pc = p;
      sb.push_back(e);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {busy, done, core_launch, core_block_id, core_thread_mask, core_pc, perf_cycles}, 64'd0);
   endtask

   // Cycle 1 is the cycle after the edge that samples start.
   task automatic run_kernel(input logic [7:0] tc, input logic [7:0] pc, input int exp_done,
                             input int exp_busy, input int dup_cyc, input int abort_cyc);
      int   done_cyc;
      int   busy_cnt;
      exp_t e;
      done_cyc = -1;
      busy_cnt = 0;
      @(negedge clk);
      start = 1'b1; thread_count = tc; base_pc = pc;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         if (core_launch != 2'b00) begin
            if (sb.size() == 0) begin
               check("extra_launch", 64'(core_launch), 64'd0);
            end else begin
               e = sb.pop_front();
               check("launch", {8'(cyc), core_launch, core_block_id, core_thread_mask, core_pc},
                               {8'(e.cyc), e.launch, e.blk, e.mask, e.pc});
            end
         end
         if (busy) busy_cnt++;
         if (cyc == abort_cyc) begin
            reset = 1'b0;
            #1;
            check_outputs_zero("midkernel_reset");
            break;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == dup_cyc) begin
            start = 1'b1; thread_count = 8'd4; base_pc = 8'h77;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("sb_empty", 64'(sb.size()), 64'd0);
      if (abort_cyc == 0) begin
         check("done_cycle", 64'(done_cyc), 64'(exp_done));
         check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
         check("perf_at_done", 64'(perf_cycles), 64'(perf_exp(exp_busy)));
         @(negedge clk);
         check("perf_hold", 64'(perf_cycles), 64'(perf_exp(exp_busy)));
         check("idle_after_done", {busy, done, core_launch}, 64'd0);
      end
      sb.delete();
   endtask

   initial begin
      int n_done;
      int n_launch;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      push(1, 2'b01, 8'd0, 4'hF, 8'h10);
      push(2, 2'b10, 8'd1, 4'hF, 8'h10);
      run_kernel(8'd8, 8'h10, 9, 8, 0, 0);

      push(1, 2'b01, 8'd0, 4'hF, 8'h20);
      push(2, 2'b10, 8'd1, 4'hF, 8'h20);
      push(8, 2'b01, 8'd2, 4'h3, 8'h20);
      run_kernel(8'd10, 8'h20, 15, 14, 0, 0);

      run_kernel(8'd0, 8'h25, 1, 0, 0, 0);

      push(1, 2'b01, 8'd0, 4'hF, 8'h30);
      run_kernel(8'd4, 8'h30, 8, 7, 2, 0);

      push(1, 2'b01, 8'd0, 4'hF, 8'h40);
      push(2, 2'b10, 8'd1, 4'hF, 8'h40);
      push(8, 2'b01, 8'd2, 4'hF, 8'h40);
      push(9, 2'b10, 8'd3, 4'h1, 8'h40);
      run_kernel(8'd13, 8'h40, 16, 15, 0, 0);

      push(1, 2'b01, 8'd0, 4'h7, 8'h50);
      run_kernel(8'd3, 8'h50, 8, 7, 0, 0);

      push(1, 2'b01, 8'd0, 4'hF, 8'h60);
      run_kernel(8'd4, 8'h60, 0, 0, 0, 3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      n_done = 0;
      n_launch = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done) n_done++;
         if (core_launch != 2'b00) n_launch++;
      end
      check("no_done_after_reset", 64'(n_done), 64'd0);
      check("no_launch_after_reset", 64'(n_launch), 64'd0);

      push(1, 2'b01, 8'd0, 4'hF, 8'h61);
      run_kernel(8'd4, 8'h61, 8, 7, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
